alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared combinational ALU.
// Grants one operation at a time and drives the ALU from registered operands.
// It waits a fixed number of cycles, then holds the captured result until the
// consumer takes it. Ties between the two requesters alternate.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  // Requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_cmd,
  // Requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_cmd,
  // Shared ALU
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_cmd,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  // Response
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_carryout,
  output logic        resp_overflow,
  output logic        resp_zero
);

  // Settle cycles remaining after the accept edge; zero means capture on the next edge.
  localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e      r_state;
  logic        r_prio;
  logic [3:0]  r_cnt;

  // Operand registers feeding the ALU
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [2:0]  r_op_cmd;
  logic        r_op_id;

  // Response registers
  logic        r_resp_valid;
  logic [31:0] r_resp_result;
  logic        r_resp_carryout;
  logic        r_resp_overflow;
  logic        r_resp_zero;

  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [2:0]  w_sel_cmd;
  logic        w_exec_done;

  // Grant: a lone requester wins; on a tie the priority bit picks the winner.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    if (r_state == StIdle) begin
      case ({req1_valid, req0_valid})
        2'b01: begin
          w_gnt_valid = 1'b1;
          w_gnt_id    = 1'b0;
        end
        2'b10: begin
          w_gnt_valid = 1'b1;
          w_gnt_id    = 1'b1;
        end
        2'b11: begin
          w_gnt_valid = 1'b1;
          w_gnt_id    = r_prio;
        end
        default: begin
          w_gnt_valid = 1'b0;
          w_gnt_id    = 1'b0;
        end
      endcase
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a   = req0_a;
    w_sel_b   = req0_b;
    w_sel_cmd = req0_cmd;
    if (w_gnt_id) begin
      w_sel_a   = req1_a;
      w_sel_b   = req1_b;
      w_sel_cmd = req1_cmd;
    end
  end

  assign req0_ready  = w_gnt_valid & ~w_gnt_id;
  assign req1_ready  = w_gnt_valid &  w_gnt_id;
  assign w_exec_done = (r_state == StExec) && (r_cnt == 4'd0);

  // Control FSM: state, settle counter and tie-break priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_prio  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_gnt_valid) begin
            r_cnt   <= CntLoad;
            r_state <= StExec;
          end
        end
        StExec: begin
          if (r_cnt == 4'd0) begin
            r_state <= StResp;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            // The requester just served yields the next tie.
            r_prio  <= ~r_op_id;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Operand capture on the request handshake; held stable until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_a   <= 32'd0;
      r_op_b   <= 32'd0;
      r_op_cmd <= 3'd0;
      r_op_id  <= 1'b0;
    end else if (w_gnt_valid) begin
      r_op_a   <= w_sel_a;
      r_op_b   <= w_sel_b;
      r_op_cmd <= w_sel_cmd;
      r_op_id  <= w_gnt_id;
    end
  end

  // Result capture at the end of the settle window; frozen while the response waits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_result   <= 32'd0;
      r_resp_carryout <= 1'b0;
      r_resp_overflow <= 1'b0;
      r_resp_zero     <= 1'b0;
    end else if (w_exec_done) begin
      r_resp_result   <= alu_result;
      r_resp_carryout <= alu_carryout;
      r_resp_overflow <= alu_overflow;
      r_resp_zero     <= alu_zero;
    end
  end

  // Registered response valid: raised on capture, dropped on the response handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= 1'b0;
    end else if (w_exec_done) begin
      r_resp_valid <= 1'b1;
    end else if (r_resp_valid && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign alu_a         = r_op_a;
  assign alu_b         = r_op_b;
  assign alu_cmd       = r_op_cmd;

  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_op_id;
  assign resp_result   = r_resp_result;
  assign resp_carryout = r_resp_carryout;
  assign resp_overflow = r_resp_overflow;
  assign resp_zero     = r_resp_zero;

endmodule
